// File: rtl/sram_sched_pkg.sv
// sram_sched_pkg: shared FSM states, op encodings and buffer sizing for sram_sched.
package sram_sched_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE} state_t;
    localparam logic OP_LOAD = 1'b0;
    localparam logic OP_STREAM = 1'b1;
    localparam int DEPTH = 32;
    localparam int OBUF_DEPTH = 3;
endpackage

// File: rtl/sram_sched_if.sv
// sram_sched_if: command, load-data, stream-data and completion signals of sram_sched.
interface sram_sched_if #(parameter int DW = 8, AW = 5);
    logic cmd_valid, cmd_ready, cmd_op;
    logic [AW-1:0] cmd_base;
    logic [AW:0] cmd_len;
    logic wr_valid, wr_ready;
    logic [DW-1:0] wr_data;
    logic rd_valid, rd_ready;
    logic [DW-1:0] rd_data;
    logic done;
    modport master (
        output cmd_valid, cmd_op, cmd_base, cmd_len, wr_valid, wr_data, rd_ready,
        input cmd_ready, wr_ready, rd_valid, rd_data, done
    );
    modport slave (
        input cmd_valid, cmd_op, cmd_base, cmd_len, wr_valid, wr_data, rd_ready,
        output cmd_ready, wr_ready, rd_valid, rd_data, done
    );
endinterface

// File: rtl/sram_sched_obuf.sv
// sram_sched_obuf: 3-entry synchronous FIFO between the SRAM read port and the stream output.
module sram_sched_obuf import sram_sched_pkg::*; #(parameter int DW = 8) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic [1:0]    count
);
    logic [DW-1:0] mem [OBUF_DEPTH];
    logic [1:0] wp, rp;

    assign dout = mem[rp];

    // storage is cleared too so the head reads 0 after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
            for (int i = 0; i < OBUF_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wp] <= din;
                wp <= wp == 2'(OBUF_DEPTH - 1) ? '0 : wp + 1'b1;
            end
            if (pop) rp <= rp == 2'(OBUF_DEPTH - 1) ? '0 : rp + 1'b1;
            count <= count + 2'(push) - 2'(pop);
        end
    end
endmodule

// File: rtl/sram_sched.sv
// sram_sched: load/stream command sequencer for one sram_32x8b buffer.
// Optional SRAM_SCHED_PERF_EN adds perf_busy, a saturating count of SRAM access cycles.
module sram_sched #(parameter int DW = 8, AW = 5, DEPTH = sram_sched_pkg::DEPTH) (
    input  logic          clk,
    input  logic          rst,
    sram_sched_if.slave   bus,
    output logic          sram_csb,
    output logic          sram_wsb,
    output logic [AW-1:0] sram_waddr,
    output logic [AW-1:0] sram_raddr,
    output logic [DW-1:0] sram_wdata,
    input  logic [DW-1:0] sram_rdata
`ifdef SRAM_SCHED_PERF_EN
    ,
    output logic [15:0]   perf_busy
`endif
);
    import sram_sched_pkg::*;

    state_t state, state_n;
    logic [AW-1:0] ptr;
    logic [AW:0] rem, ileft, len_sat;
    logic [1:0] ocount;
    logic inflight, cmd_fire, wr_fire, rd_issue, pop, last;

    assign len_sat = bus.cmd_len > (AW+1)'(DEPTH) ? (AW+1)'(DEPTH) : bus.cmd_len;
    assign bus.cmd_ready = state == IDLE && !rst;
    assign bus.wr_ready = state == LOAD;
    assign bus.rd_valid = ocount != '0;
    assign bus.done = state == DONE;
    assign cmd_fire = bus.cmd_valid && bus.cmd_ready;
    assign wr_fire = bus.wr_valid && bus.wr_ready;
    assign pop = bus.rd_valid && bus.rd_ready;
    assign last = rem == (AW+1)'(1);
    // a read is only issued when its word is guaranteed a buffer slot
    assign rd_issue = state == STREAM && ileft != '0 && {1'b0, ocount} + {2'b0, inflight} < 3'd3;
    assign sram_csb = !(wr_fire || rd_issue);
    assign sram_wsb = !wr_fire;
    assign sram_waddr = ptr;
    assign sram_raddr = ptr;
    assign sram_wdata = bus.wr_data;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (cmd_fire) state_n = len_sat == '0 ? DONE : bus.cmd_op == OP_LOAD ? LOAD : STREAM;
            LOAD: if (wr_fire && last) state_n = DONE;
            STREAM: if (pop && last) state_n = DONE;
            default: state_n = IDLE;
        endcase
    end

    // rem counts words still to write (LOAD) or to deliver (STREAM); ileft counts reads not yet issued
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
            rem <= '0;
            ileft <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= rd_issue;
            if (cmd_fire) begin
                ptr <= bus.cmd_base;
                rem <= len_sat;
                ileft <= len_sat;
            end
            if (wr_fire || rd_issue) ptr <= ptr + 1'b1;
            if (wr_fire || pop) rem <= rem - 1'b1;
            if (rd_issue) ileft <= ileft - 1'b1;
        end
    end

    sram_sched_obuf #(.DW(DW)) obuf (
        .clk(clk),
        .rst(rst),
        .push(inflight),
        .pop(pop),
        .din(sram_rdata),
        .dout(bus.rd_data),
        .count(ocount)
    );

`ifdef SRAM_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) perf_busy <= '0;
        else if (!sram_csb && perf_busy != 16'hFFFF) perf_busy <= perf_busy + 1'b1;
    end
`endif
endmodule
